// File: rtl/twobit_seq_core.sv
// twobit_seq_core: two-cycle (FETCH/EXEC) instruction sequencer that reads a
// 4-entry x 2-bit instruction memory. It runs INC/JNO/HLT on an unsigned
// accumulator that has an overflow flag.
// Optional feature macro: INSTR_COUNT_EN adds a saturating 16-bit count of
// executed instructions on port instr_count.
module twobit_seq_core #(
  parameter int         ACC_WIDTH  = 4,
  parameter logic [1:0] JNO_TARGET = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [1:0]           mem_sel,
  input  logic [1:0]           mem_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ACC_WIDTH-1:0] acc,
`ifdef INSTR_COUNT_EN
  output logic [15:0]          instr_count,
`endif
  output logic                 ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;

  state_t               state_q, state_d;
  logic [1:0]           pc_q, pc_d;
  logic [1:0]           instr_q, instr_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic [ACC_WIDTH:0]   acc_sum;

  // Increment with a carry bit; the carry becomes the new overflow flag.
  assign acc_sum = {1'b0, acc_q} + {{ACC_WIDTH{1'b0}}, 1'b1};

  // State and datapath registers, async reset to the idle/cleared state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= 2'd0;
      instr_q <= 2'd0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath decode; everything holds unless changed below.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        // start is only honoured while not busy; a restart clears results.
        if (start) begin
          pc_d    = 2'd0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = mem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (instr_q)
          OP_INC: begin
            acc_d   = acc_sum[ACC_WIDTH-1:0];
            ovf_d   = acc_sum[ACC_WIDTH];
            pc_d    = pc_q + 2'd1;
            state_d = S_FETCH;
          end
          OP_JNO: begin
            pc_d    = ovf_q ? (pc_q + 2'd1) : JNO_TARGET;
            state_d = S_FETCH;
          end
          OP_HLT: begin
            state_d = S_HALT;
          end
          default: begin
            // Reserved opcode: stop and flag the error.
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating instruction counter, cleared on an accepted start.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_IDLE || state_q == S_HALT) && start) begin
      cnt_d = 16'd0;
    end else if (state_q == S_EXEC && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

  // Memory address comes straight from the registered PC.
  assign mem_sel = pc_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign done    = (state_q == S_HALT);
  assign err     = err_q;
  assign acc     = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_twobit_seq_core.sv
// Directed testbench for twobit_seq_core. It uses three instances (ACC_WIDTH
// 4, 2 and 1), and each instance has its own behavioural instruction memory.
module tb_twobit_seq_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- ACC_WIDTH = 4 instance ----------------
  logic       start4 = 1'b0;
  logic [1:0] mem4 [4];
  logic [1:0] ms4, md4;
  logic       busy4, done4, err4, ovf4;
  logic [3:0] acc4;
  assign md4 = mem4[ms4];

  // ---------------- ACC_WIDTH = 2 instance ----------------
  logic       start2 = 1'b0;
  logic [1:0] mem2 [4];
  logic [1:0] ms2, md2;
  logic       busy2, done2, err2, ovf2;
  logic [1:0] acc2;
  assign md2 = mem2[ms2];

  // ---------------- ACC_WIDTH = 1 instance ----------------
  logic       start1 = 1'b0;
  logic [1:0] mem1 [4];
  logic [1:0] ms1, md1;
  logic       busy1, done1, err1, ovf1;
  logic [0:0] acc1;
  assign md1 = mem1[ms1];

`ifdef INSTR_COUNT_EN
  logic [15:0] ic4, ic2, ic1;
`endif

  twobit_seq_core #(.ACC_WIDTH(4), .JNO_TARGET(2'd0)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mem_sel(ms4), .mem_data(md4),
    .busy(busy4), .done(done4), .err(err4), .acc(acc4),
`ifdef INSTR_COUNT_EN
    .instr_count(ic4),
`endif
    .ovf(ovf4));

  twobit_seq_core #(.ACC_WIDTH(2), .JNO_TARGET(2'd0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mem_sel(ms2), .mem_data(md2),
    .busy(busy2), .done(done2), .err(err2), .acc(acc2),
`ifdef INSTR_COUNT_EN
    .instr_count(ic2),
`endif
    .ovf(ovf2));

  twobit_seq_core #(.ACC_WIDTH(1), .JNO_TARGET(2'd0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mem_sel(ms1), .mem_data(md1),
    .busy(busy1), .done(done1), .err(err1), .acc(acc1),
`ifdef INSTR_COUNT_EN
    .instr_count(ic1),
`endif
    .ovf(ovf1));

  // One-cycle start pulse on dut4; returns at the first FETCH cycle.
  task automatic pulse4();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy4, done4, err4, ovf4, acc4, ms4} !== 10'd0)
      $display("FAIL reset_state4 got busy=%b done=%b err=%b ovf=%b acc=%0d sel=%0d want all 0",
               busy4, done4, err4, ovf4, acc4, ms4);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy4, done4, busy2, done2, busy1, done1} !== 6'd0)
      $display("FAIL idle_after_reset got busy4=%b done4=%b busy2=%b done2=%b busy1=%b done1=%b want 0",
               busy4, done4, busy2, done2, busy1, done1);
    else n_pass++;
    $display("test_reset: done");
  endtask

  task automatic test_inc3();
    logic [1:0] exp_sel;
    mem4[0] = 2'b00; mem4[1] = 2'b00; mem4[2] = 2'b00; mem4[3] = 2'b10;
    pulse4();
    for (int i = 0; i < 8; i++) begin
      exp_sel = 2'(i / 2);
      n_checks++;
      if (ms4 !== exp_sel || busy4 !== 1'b1 || done4 !== 1'b0)
        $display("FAIL inc3_cycle%0d got sel=%0d busy=%b done=%b want sel=%0d busy=1 done=0",
                 i, ms4, busy4, done4, exp_sel);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || acc4 !== 4'd3 || ovf4 !== 1'b0 || err4 !== 1'b0)
      $display("FAIL inc3_result got done=%b busy=%b acc=%0d ovf=%b err=%b want done=1 busy=0 acc=3 ovf=0 err=0",
               done4, busy4, acc4, ovf4, err4);
    else n_pass++;
`ifdef INSTR_COUNT_EN
    n_checks++;
    if (ic4 !== 16'd4) $display("FAIL inc3_count got %0d want 4", ic4);
    else n_pass++;
`endif
    $display("test_inc3: acc=%0d ovf=%b done=%b", acc4, ovf4, done4);
  endtask

  task automatic test_start_busy();
    pulse4();  // restart from HALT: results clear immediately
    n_checks++;
    if (acc4 !== 4'd0 || done4 !== 1'b0 || busy4 !== 1'b1)
      $display("FAIL restart_clear got acc=%0d done=%b busy=%b want acc=0 done=0 busy=1",
               acc4, done4, busy4);
    else n_pass++;
    repeat (2) @(negedge clk);
    start4 = 1'b1;  // ignored: core is busy
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done4 !== 1'b0 || busy4 !== 1'b1)
      $display("FAIL busy_start_early got done=%b busy=%b want done=0 busy=1", done4, busy4);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done4 !== 1'b1 || acc4 !== 4'd3 || ovf4 !== 1'b0)
      $display("FAIL busy_start_result got done=%b acc=%0d ovf=%b want done=1 acc=3 ovf=0",
               done4, acc4, ovf4);
    else n_pass++;
    $display("test_start_busy: acc=%0d done=%b", acc4, done4);
  endtask

  task automatic test_err();
    mem4[0] = 2'b00; mem4[1] = 2'b11; mem4[2] = 2'b00; mem4[3] = 2'b00;
    pulse4();
    repeat (3) @(negedge clk);
    n_checks++;
    if (done4 !== 1'b0) $display("FAIL err_early_done got done=%b want 0", done4);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done4 !== 1'b1 || err4 !== 1'b1 || acc4 !== 4'd1 || ms4 !== 2'd1)
      $display("FAIL err_result got done=%b err=%b acc=%0d sel=%0d want done=1 err=1 acc=1 sel=1",
               done4, err4, acc4, ms4);
    else n_pass++;
    $display("test_err: err=%b acc=%0d sel=%0d", err4, acc4, ms4);
  endtask

  task automatic test_restart_after_err();
    mem4[0] = 2'b00; mem4[1] = 2'b00; mem4[2] = 2'b00; mem4[3] = 2'b10;
    pulse4();
    n_checks++;
    if (err4 !== 1'b0 || acc4 !== 4'd0)
      $display("FAIL restart_err_clear got err=%b acc=%0d want err=0 acc=0", err4, acc4);
    else n_pass++;
    repeat (8) @(negedge clk);
    n_checks++;
    if (done4 !== 1'b1 || acc4 !== 4'd3 || err4 !== 1'b0)
      $display("FAIL restart_result got done=%b acc=%0d err=%b want done=1 acc=3 err=0",
               done4, acc4, err4);
    else n_pass++;
    $display("test_restart_after_err: acc=%0d err=%b", acc4, err4);
  endtask

  task automatic test_jno_wrap();
    mem2[0] = 2'b00; mem2[1] = 2'b01; mem2[2] = 2'b00; mem2[3] = 2'b10;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;   // cycle 1 (first FETCH)
    repeat (14) @(negedge clk);      // cycle 15: after 7th instruction (INC wraps)
    n_checks++;
    if (acc2 !== 2'd0 || ovf2 !== 1'b1 || ms2 !== 2'd1)
      $display("FAIL jno_overflow got acc=%0d ovf=%b sel=%0d want acc=0 ovf=1 sel=1", acc2, ovf2, ms2);
    else n_pass++;
    repeat (2) @(negedge clk);       // cycle 17: JNO fell through
    n_checks++;
    if (ms2 !== 2'd2) $display("FAIL jno_fallthrough got sel=%0d want 2", ms2);
    else n_pass++;
    repeat (2) @(negedge clk);       // cycle 19: INC cleared ovf
    n_checks++;
    if (acc2 !== 2'd1 || ovf2 !== 1'b0)
      $display("FAIL jno_inc_after got acc=%0d ovf=%b want acc=1 ovf=0", acc2, ovf2);
    else n_pass++;
    @(negedge clk);                  // cycle 20: EXEC of HLT
    n_checks++;
    if (done2 !== 1'b0) $display("FAIL jno_early_done got done=%b want 0", done2);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done2 !== 1'b1 || err2 !== 1'b0 || acc2 !== 2'd1 || ms2 !== 2'd3)
      $display("FAIL jno_result got done=%b err=%b acc=%0d sel=%0d want done=1 err=0 acc=1 sel=3",
               done2, err2, acc2, ms2);
    else n_pass++;
`ifdef INSTR_COUNT_EN
    n_checks++;
    if (ic2 !== 16'd10) $display("FAIL jno_count got %0d want 10", ic2);
    else n_pass++;
`endif
    $display("test_jno_wrap: acc=%0d ovf=%b done=%b", acc2, ovf2, done2);
  endtask

  task automatic test_nohlt();
    logic       exp_acc, exp_ovf, all_busy;
    logic [1:0] exp_sel;
    mem1[0] = 2'b00; mem1[1] = 2'b00; mem1[2] = 2'b00; mem1[3] = 2'b00;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      repeat (2) @(negedge clk);
      exp_acc = (k % 2) == 1;
      exp_ovf = (k % 2) == 0;
      exp_sel = 2'(k % 4);
      n_checks++;
      if (acc1 !== exp_acc || ovf1 !== exp_ovf || ms1 !== exp_sel)
        $display("FAIL nohlt_inc%0d got acc=%b ovf=%b sel=%0d want acc=%b ovf=%b sel=%0d",
                 k, acc1, ovf1, ms1, exp_acc, exp_ovf, exp_sel);
      else n_pass++;
    end
    all_busy = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy1 !== 1'b1 || done1 !== 1'b0) all_busy = 1'b0;
    end
    n_checks++;
    if (all_busy !== 1'b1) $display("FAIL nohlt_busy100 got all_busy=%b want 1", all_busy);
    else n_pass++;
    $display("test_nohlt: busy held for 100 cycles, acc=%b", acc1);
  endtask

  task automatic test_reset_midrun();
    mem4[0] = 2'b00; mem4[1] = 2'b00; mem4[2] = 2'b00; mem4[3] = 2'b10;
    pulse4();
    repeat (6) @(negedge clk);   // three instructions executed
    n_checks++;
    if (acc4 !== 4'd3 || busy4 !== 1'b1)
      $display("FAIL midrun_pre got acc=%0d busy=%b want acc=3 busy=1", acc4, busy4);
    else n_pass++;
    #2 reset = 1'b1;
    #1;                          // no clock edge yet: reset must act alone
    n_checks++;
    if ({busy4, done4, ovf4, acc4, ms4, busy1} !== 10'd0)
      $display("FAIL midrun_async got busy=%b done=%b ovf=%b acc=%0d sel=%0d busy1=%b want all 0",
               busy4, done4, ovf4, acc4, ms4, busy1);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || ms4 !== 2'd0)
      $display("FAIL midrun_stay_idle got busy=%b done=%b sel=%0d want 0 0 0", busy4, done4, ms4);
    else n_pass++;
    $display("test_reset_midrun: busy=%b done=%b", busy4, done4);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem4[i] = 2'b10; mem2[i] = 2'b10; mem1[i] = 2'b10;
    end
    test_reset();
    test_inc3();
    test_start_busy();
    test_err();
    test_restart_after_err();
    test_jno_wrap();
    test_nohlt();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
